nn_layer: RTL and testbench
===========================

NN_LAYER -- requirements
Module: nn_layer

Interface
REQ-001 SHALL have parameter DATA_LEN, default 16, meaning signed fixed-point width of inputs, weights and outputs.
REQ-002 SHALL have parameter FRAC_LEN, default 8, meaning the number of fractional bits (1.0 = 2^FRAC_LEN).
REQ-003 SHALL have parameter NUM_IN, default 4, meaning the number of inputs per frame.
REQ-004 SHALL have parameter NUM_NEURONS, default 4, meaning the number of neurons computed in parallel.
REQ-005 SHALL have ports clk_i (in, 1, the only clock) and reset_ni (in, 1, synchronous active-low reset).
REQ-006 SHALL have weight write ports w_we_i (in, 1, write enable), w_addr_i (in, $clog2(NUM_NEURONS*NUM_IN), address n*NUM_IN+k) and w_data_i (in, DATA_LEN, signed weight).
REQ-007 SHALL have input stream ports in_valid_i (in, 1), in_ready_o (out, 1) and in_data_i (in, DATA_LEN, signed x_k).
REQ-008 SHALL have output stream ports out_valid_o (out, 1), out_ready_i (in, 1), out_data_o (out, DATA_LEN, signed y_n) and out_idx_o (out, $clog2(NUM_NEURONS), neuron index n).

Function
REQ-009 SHALL implement a two-state FSM: ACCUM (in_ready_o=1, out_valid_o=0) and DRAIN (in_ready_o=0, out_valid_o=1).
REQ-010 SHALL count a beat as accepted in ACCUM when in_valid_i=1; the input counter k SHALL advance 0..NUM_IN-1 on accepted beats only.
REQ-011 SHALL, on each accepted beat, add w[n][k]*x_k to accumulator n for every n in the same cycle.
REQ-012 SHALL size each accumulator at 2*DATA_LEN+$clog2(NUM_IN) bits so that no intermediate overflow occurs.
REQ-013 SHALL move to DRAIN on the cycle after acceptance of beat k=NUM_IN-1, clear k, and present neuron 0 on that cycle (one-cycle latency).
REQ-014 SHALL compute y_n as the accumulator shifted arithmetically right by FRAC_LEN (truncation toward minus infinity), then saturated to [-2^(DATA_LEN-1), 2^(DATA_LEN-1)-1], then passed through the activation of REQ-022/023.
REQ-015 SHALL, in DRAIN, emit one neuron per out_valid_o&&out_ready_i handshake, in order idx 0..NUM_NEURONS-1.
REQ-016 SHALL hold out_data_o and out_idx_o stable while out_valid_o=1 and out_ready_i=0.
REQ-017 SHALL, after the handshake of idx NUM_NEURONS-1, clear all accumulators and return to ACCUM on the next cycle.
REQ-018 SHALL accept weight writes in any state; a write SHALL take effect on beats accepted from the next cycle onward, and a simultaneous write and use of the same weight SHALL use the old value.

Reset
REQ-019 SHALL, on clk_i rising edge with reset_ni=0, set state=ACCUM, k=0, idx=0, all accumulators=0, out_valid_o=0 and out_data_o=0; in_ready_o SHALL be 0 while reset_ni=0.
REQ-020 SHALL discard a partial frame or partial drain on reset, with no output emitted for it.
REQ-021 SHALL leave weight memory contents unaffected by reset.

Configuration
REQ-022 SHALL apply ReLU (negative y_n replaced by 0 after saturation) when NN_LAYER_RELU_EN is defined.
REQ-023 SHALL apply identity activation (saturated value passed unchanged) when NN_LAYER_RELU_EN is not defined.

Structure
REQ-024 SHALL take the shared package nn_pkg, which SHALL contain the FSM state enum, the default fixed-point constants (DATA_LEN, FRAC_LEN) and a saturate function.
REQ-025 SHALL place the per-neuron multiply/accumulate/shift/saturate/activate datapath in one sub-module nn_neuron, instantiated NUM_NEURONS times by a generate loop.

Verification (DATA_LEN=16, FRAC_LEN=8, NUM_IN=4, NUM_NEURONS=4)
REQ-026 SHALL cover: w[n][k]=256 for n==k, otherwise 0, with inputs 256, 512, 768, -256 -> outputs idx0..3 = 256, 512, 768, -256 (0 with NN_LAYER_RELU_EN), out_valid_o 1 cycle after the last accepted input.
REQ-027 SHALL cover: all weights 0x7FFF, all inputs 0x7FFF -> every output 0x7FFF; all weights 0x8000, all inputs 0x7FFF -> every output 0x8000 (0 with NN_LAYER_RELU_EN).
REQ-028 SHALL cover: out_ready_i held low 3 cycles at idx 1 -> out_data_o and out_idx_o held stable, in_ready_o=0, no output skipped or repeated.
REQ-029 SHALL cover: in_valid_i gaps of 2 cycles between beats -> results identical to REQ-026.
REQ-030 SHALL cover: reset_ni driven low for 1 cycle after 2 accepted beats, then a full REQ-026 frame -> exactly 4 outputs matching REQ-026 (weights retained).
REQ-031 SHALL cover: w[0][3] rewritten to 512 in the same cycle that beat k=3 is accepted -> y_0 uses the old weight; the next frame uses 512.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared FSM state, fixed-point defaults and saturation helper for nn_layer
package nn_pkg;

  localparam int DATA_LEN = 16;
  localparam int FRAC_LEN = 8;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Clamp a sign-extended value to the signed range of a width-bit word (width <= 64).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi)      saturate = hi;
    else if (v < lo) saturate = lo;
    else             saturate = v;
  endfunction

endpackage

// File: rtl/nn_neuron.sv
// rtl/nn_neuron.sv - one neuron: MAC accumulator, FRAC_LEN shift, saturate, activation
// Activation is ReLU when NN_LAYER_RELU_EN is defined, identity otherwise.
module nn_neuron
  import nn_pkg::*;
#(
  parameter int DATA_LEN = nn_pkg::DATA_LEN,
  parameter int FRAC_LEN = nn_pkg::FRAC_LEN,
  parameter int ACC_LEN  = 2 * nn_pkg::DATA_LEN + 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       acc_en,
  input  logic signed [DATA_LEN-1:0] x,
  input  logic signed [DATA_LEN-1:0] w,
  output logic signed [DATA_LEN-1:0] y
);

  logic signed [2*DATA_LEN-1:0] prod;
  logic signed [ACC_LEN-1:0]    acc_q;
  logic signed [ACC_LEN-1:0]    shifted;
  logic signed [DATA_LEN-1:0]   sat;

  assign prod = w * x;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      acc_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_q + ACC_LEN'(prod);
    end
  end

  // Arithmetic shift truncates toward minus infinity.
  assign shifted = acc_q >>> FRAC_LEN;
  assign sat     = DATA_LEN'(saturate(64'(shifted), DATA_LEN));

`ifdef NN_LAYER_RELU_EN
  assign y = sat[DATA_LEN-1] ? '0 : sat;
`else
  assign y = sat;
`endif

endmodule

// File: rtl/nn_layer.sv
// rtl/nn_layer.sv - fully connected layer: streams NUM_IN inputs, drains NUM_NEURONS outputs
// Optional ReLU activation selected by defining NN_LAYER_RELU_EN.
module nn_layer
  import nn_pkg::*;
#(
  parameter int DATA_LEN    = nn_pkg::DATA_LEN,
  parameter int FRAC_LEN    = nn_pkg::FRAC_LEN,
  parameter int NUM_IN      = 4,
  parameter int NUM_NEURONS = 4
) (
  input  logic                                    clk_i,
  input  logic                                    reset_ni,
  input  logic                                    w_we_i,
  input  logic [$clog2(NUM_NEURONS*NUM_IN)-1:0]   w_addr_i,
  input  logic signed [DATA_LEN-1:0]              w_data_i,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic signed [DATA_LEN-1:0]              in_data_i,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic signed [DATA_LEN-1:0]              out_data_o,
  output logic [$clog2(NUM_NEURONS)-1:0]          out_idx_o
);

  localparam int ADDR_W  = $clog2(NUM_NEURONS * NUM_IN);
  localparam int K_W     = $clog2(NUM_IN);
  localparam int IDX_W   = $clog2(NUM_NEURONS);
  localparam int ACC_LEN = 2 * DATA_LEN + $clog2(NUM_IN);

  state_t state_q;
  state_t state_d;

  logic [K_W-1:0]   k_q;
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             out_fire;
  logic             last_beat;
  logic             last_out;

  logic signed [DATA_LEN-1:0] w_mem [NUM_NEURONS*NUM_IN];
  logic signed [DATA_LEN-1:0] y_all [NUM_NEURONS];

  assign accept    = in_ready_o && in_valid_i;
  assign out_fire  = out_valid_o && out_ready_i;
  assign last_beat = accept && (k_q == K_W'(NUM_IN - 1));
  assign last_out  = out_fire && (idx_q == IDX_W'(NUM_NEURONS - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (last_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (last_out)  state_d = ST_ACCUM;
      default:                 state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      ST_ACCUM: in_ready_o  = reset_ni;
      ST_DRAIN: out_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      k_q   <= '0;
      idx_q <= '0;
    end else begin
      if (accept) begin
        k_q <= last_beat ? '0 : k_q + K_W'(1);
      end
      if (out_fire) begin
        idx_q <= last_out ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Weight memory survives reset; reads are combinational so a same-cycle write is seen next cycle.
  always_ff @(posedge clk_i) begin
    if (w_we_i) begin
      w_mem[w_addr_i] <= w_data_i;
    end
  end

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    nn_neuron #(
      .DATA_LEN (DATA_LEN),
      .FRAC_LEN (FRAC_LEN),
      .ACC_LEN  (ACC_LEN)
    ) u_neuron (
      .clk    (clk_i),
      .resetn (reset_ni),
      .clear  (last_out),
      .acc_en (accept),
      .x      (in_data_i),
      .w      (w_mem[ADDR_W'(n * NUM_IN) + ADDR_W'(k_q)]),
      .y      (y_all[n])
    );
  end

  assign out_data_o = y_all[idx_q];
  assign out_idx_o  = idx_q;

endmodule

// File: tb/tb_nn_layer.sv
// tb/tb_nn_layer.sv - scoreboard bench for nn_layer against an arithmetic reference model
module tb_nn_layer;

  localparam int DL = 16;
  localparam int FL = 8;
  localparam int NI = 4;
  localparam int NN = 4;

  typedef int frame_t [NI];
  typedef struct { int idx; int data; } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_ni = 1'b0;
  logic                 w_we_i = 1'b0;
  logic [3:0]           w_addr_i = '0;
  logic signed [DL-1:0] w_data_i = '0;
  logic                 in_valid_i = 1'b0;
  logic                 in_ready_o;
  logic signed [DL-1:0] in_data_i = '0;
  logic                 out_valid_o;
  logic                 out_ready_i = 1'b1;
  logic signed [DL-1:0] out_data_o;
  logic [1:0]           out_idx_o;

  always #5 clk = ~clk;

  nn_layer #(.DATA_LEN(DL), .FRAC_LEN(FL), .NUM_IN(NI), .NUM_NEURONS(NN)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .w_we_i      (w_we_i),
    .w_addr_i    (w_addr_i),
    .w_data_i    (w_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o)
  );

  int   checks = 0;
  int   failures = 0;
  int   wm [NN*NI];
  exp_t exp_q [$];
  int   ready_mode = 0;
  int   stall_left = 0;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  // y = floor(sum / 2^FL), clamped to DL bits, then activation.
  function automatic int ref_out(longint s);
    longint q;
    q = s / (64'sd1 << FL);
    if (s < 0 && (s % (64'sd1 << FL)) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`ifdef NN_LAYER_RELU_EN
    if (q < 0) q = 0;
`endif
    return int'(q);
  endfunction

  task automatic write_weight(int a, int v);
    @(negedge clk);
    w_we_i = 1'b1; w_addr_i = 4'(a); w_data_i = DL'(v);
    @(posedge clk);
    wm[a] = v;
    #1 w_we_i = 1'b0;
  endtask

  task automatic load_identity();
    for (int a = 0; a < NN*NI; a++) write_weight(a, (a / NI == a % NI) ? 256 : 0);
  endtask

  task automatic send_frame(frame_t x, int gap, bit do_wr, int wa, int wv);
    longint acc [NN];
    int t;
    for (int n = 0; n < NN; n++) acc[n] = 0;
    for (int k = 0; k < NI; k++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); in_valid_i = 1'b0;
      end
      @(negedge clk);
      in_valid_i = 1'b1; in_data_i = DL'(x[k]);
      if (do_wr && k == NI-1) begin
        w_we_i = 1'b1; w_addr_i = 4'(wa); w_data_i = DL'(wv);
      end
      t = 0;
      while (!in_ready_o && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) check("in_ready_timeout", 0, 1);
      @(posedge clk);
      for (int n = 0; n < NN; n++) acc[n] += longint'(wm[n*NI+k]) * longint'(x[k]);
      if (do_wr && k == NI-1) wm[wa] = wv;
    end
    for (int n = 0; n < NN; n++) exp_q.push_back('{idx: n, data: ref_out(acc[n])});
    @(negedge clk);
    in_valid_i = 1'b0; w_we_i = 1'b0;
    check("out_valid_latency", out_valid_o, 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid_o) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) check("drain_timeout", exp_q.size(), 0);
  endtask

  // Ready driver: optional 3-cycle stall at idx 1, otherwise always-ready or random.
  initial forever begin
    @(negedge clk);
    if (stall_left > 0 && out_valid_o && out_idx_o == 2'd1) begin
      out_ready_i = 1'b0; stall_left--;
    end else if (ready_mode == 1) out_ready_i = 1'($urandom_range(0, 1));
    else out_ready_i = 1'b1;
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    bit             prev_stall = 1'b0;
    logic [DL-1:0]  prev_data = '0;
    logic [1:0]     prev_idx = '0;
    exp_t           e;
    forever begin
      @(negedge clk); #1;
      if (reset_ni && out_valid_o) begin
        check("in_ready_in_drain", in_ready_o, 0);
        if (prev_stall) begin
          check("hold_data", out_data_o, $signed(prev_data));
          check("hold_idx", out_idx_o, prev_idx);
        end
        if (out_ready_i) begin
          if (exp_q.size() == 0) check("unexpected_output", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("out_idx", out_idx_o, e.idx);
            check("out_data", out_data_o, e.data);
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1; prev_data = out_data_o; prev_idx = out_idx_o;
        end
      end else prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    frame_t f, fr;
    f = '{256, 512, 768, -256};

    @(negedge clk);
    check("reset_in_ready", in_ready_o, 0);
    @(negedge clk);
    check("reset_out_valid", out_valid_o, 0);
    check("reset_out_data", out_data_o, 0);
    reset_ni = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready_o, 1);

    load_identity();
    send_frame(f, 0, 1'b0, 0, 0);
    wait_drain();

    for (int a = 0; a < NN*NI; a++) write_weight(a, 32767);
    send_frame('{32767, 32767, 32767, 32767}, 0, 1'b0, 0, 0);
    wait_drain();
    for (int a = 0; a < NN*NI; a++) write_weight(a, -32768);
    send_frame('{32767, 32767, 32767, 32767}, 0, 1'b0, 0, 0);
    wait_drain();

    load_identity();
    stall_left = 3;
    send_frame(f, 0, 1'b0, 0, 0);
    wait_drain();
    check("stall_consumed", stall_left, 0);

    send_frame(f, 2, 1'b0, 0, 0);
    wait_drain();

    for (int k = 0; k < 2; k++) begin
      @(negedge clk); in_valid_i = 1'b1; in_data_i = DL'(f[k]);
      @(posedge clk);
    end
    @(negedge clk); in_valid_i = 1'b0; reset_ni = 1'b0;
    @(negedge clk);
    check("mid_reset_in_ready", in_ready_o, 0);
    reset_ni = 1'b1;
    send_frame(f, 0, 1'b0, 0, 0);
    wait_drain();

    send_frame(f, 0, 1'b1, 3, 512);
    wait_drain();
    send_frame(f, 1, 1'b0, 0, 0);
    wait_drain();

    ready_mode = 1;
    for (int i = 0; i < 15; i++) begin
      for (int a = 0; a < NN*NI; a++)
        write_weight(a, (i % 3 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                     : int'($urandom_range(0, 1023)) - 512);
      for (int k = 0; k < NI; k++)
        fr[k] = (i % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                             : int'($urandom_range(0, 2047)) - 1024;
      send_frame(fr, int'($urandom_range(0, 2)), 1'b0, 0, 0);
    end
    wait_drain();
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
